// File: rtl/ahb_lite_cmd_master_if.sv
// Bundle of the command/response stream and the AHB-lite master bus.
// The master modport is the initiator's view; slave is the stimulus/slave side.
interface ahb_lite_cmd_master_if #(
  parameter int ADDR_W = 32
) ();

  logic              I_CMD_VALID;
  logic              O_CMD_READY;
  logic              I_CMD_WRITE;
  logic [ADDR_W-1:0] I_CMD_ADDR;
  logic [1:0]        I_CMD_SIZE;
  logic [31:0]       I_CMD_WDATA;

  logic              O_RSP_VALID;
  logic [31:0]       O_RSP_RDATA;
  logic              O_RSP_ERR;

  logic [ADDR_W-1:0] O_HADDR;
  logic [1:0]        O_HTRANS;
  logic              O_HWRITE;
  logic [2:0]        O_HSIZE;
  logic [2:0]        O_HBURST;
  logic              O_HMASTLOCK;
  logic [3:0]        O_HPROT;
  logic [31:0]       O_HWDATA;
  logic [31:0]       I_HRDATA;
  logic              I_HREADY;
  logic              I_HRESP;

  modport master (
    input  I_CMD_VALID, I_CMD_WRITE, I_CMD_ADDR, I_CMD_SIZE, I_CMD_WDATA,
    output O_CMD_READY,
    output O_RSP_VALID, O_RSP_RDATA, O_RSP_ERR,
    output O_HADDR, O_HTRANS, O_HWRITE, O_HSIZE, O_HBURST, O_HMASTLOCK,
    output O_HPROT, O_HWDATA,
    input  I_HRDATA, I_HREADY, I_HRESP
  );

  modport slave (
    output I_CMD_VALID, I_CMD_WRITE, I_CMD_ADDR, I_CMD_SIZE, I_CMD_WDATA,
    input  O_CMD_READY,
    input  O_RSP_VALID, O_RSP_RDATA, O_RSP_ERR,
    input  O_HADDR, O_HTRANS, O_HWRITE, O_HSIZE, O_HBURST, O_HMASTLOCK,
    input  O_HPROT, O_HWDATA,
    output I_HRDATA, I_HREADY, I_HRESP
  );

endinterface

// File: rtl/ahb_lite_cmd_master.sv
// AHB-lite single-master initiator: converts a command stream into NONSEQ
// SINGLE transfers through a two-slot (address phase / data phase) pipeline,
// handles wait states, the two-cycle ERROR response and byte-lane steering,
// and returns one in-order response per command.
module ahb_lite_cmd_master #(
  parameter int         ADDR_W    = 32,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic                  I_HCLK,
  input  logic                  I_HRESETn,
  ahb_lite_cmd_master_if.master bus
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Address-phase slot
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [1:0]        a_size;
  logic              a_write;
  logic [31:0]       a_wdata;

  // Data-phase slot
  logic              d_valid;
  logic              d_write;
  logic [1:0]        d_addr_lo;
  logic [1:0]        d_size;
  logic [31:0]       d_wdata;

  logic              cancel;
  logic              run;

  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  logic              cmd_mis;
  logic              cmd_ready;
  logic              accept_aligned;
  logic              accept_mis;
  logic              d_done;
  logic              a_move;
  logic [31:0]       rd_extract;

  // Replicates narrow write data onto every byte lane it could occupy.
  function automatic logic [31:0] place_lanes(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] res;
    case (size)
      2'd0:    res = {4{data[7:0]}};
      2'd1:    res = {2{data[15:0]}};
      default: res = data;
    endcase
    return res;
  endfunction

  // Picks the addressed lanes out of the read bus and zero-extends them.
  function automatic logic [31:0] pick_lanes(input logic [1:0] size, input logic [1:0] lo,
                                             input logic [31:0] data);
    logic [31:0] shifted;
    logic [31:0] res;
    shifted = data >> {lo, 3'b000};
    case (size)
      2'd0:    res = {24'h0, shifted[7:0]};
      2'd1:    res = lo[1] ? {16'h0, data[31:16]} : {16'h0, data[15:0]};
      default: res = data;
    endcase
    return res;
  endfunction

  // Flags commands that can never be put on the bus.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return (size == 2'd3) || (size == 2'd1 && lo[0]) || (size == 2'd2 && lo != 2'b00);
  endfunction

  // Acceptance rules: misaligned commands wait for a fully drained pipeline.
  always_comb begin
    cmd_mis        = is_misaligned(bus.I_CMD_SIZE, bus.I_CMD_ADDR[1:0]);
    cmd_ready      = 1'b0;
    if (run) begin
      if (cmd_mis) cmd_ready = ~a_valid & ~d_valid & ~cancel;
      else         cmd_ready = (~a_valid | bus.I_HREADY) & ~cancel;
    end
    accept_aligned = bus.I_CMD_VALID & cmd_ready & ~cmd_mis;
    accept_mis     = bus.I_CMD_VALID & cmd_ready & cmd_mis;
    d_done         = d_valid & bus.I_HREADY;
    a_move         = a_valid & bus.I_HREADY & ~cancel;
    rd_extract     = pick_lanes(d_size, d_addr_lo, bus.I_HRDATA);
  end

  // Holds READY low until the first clock after reset release.
  always_ff @(posedge I_HCLK or negedge I_HRESETn) begin
    if (!I_HRESETn) run <= 1'b0;
    else            run <= 1'b1;
  end

  // Address-phase slot: load on accept, empty when it moves to data phase.
  always_ff @(posedge I_HCLK or negedge I_HRESETn) begin
    if (!I_HRESETn) begin
      a_valid <= 1'b0;
      a_addr  <= '0;
      a_size  <= 2'd0;
      a_write <= 1'b0;
      a_wdata <= 32'h0;
    end else if (accept_aligned) begin
      a_valid <= 1'b1;
      a_addr  <= bus.I_CMD_ADDR;
      a_size  <= bus.I_CMD_SIZE;
      a_write <= bus.I_CMD_WRITE;
      a_wdata <= bus.I_CMD_WDATA;
    end else if (a_move) begin
      a_valid <= 1'b0;
    end
  end

  // Data-phase slot: advances on every ready edge; write lanes registered here.
  always_ff @(posedge I_HCLK or negedge I_HRESETn) begin
    if (!I_HRESETn) begin
      d_valid   <= 1'b0;
      d_write   <= 1'b0;
      d_addr_lo <= 2'b00;
      d_size    <= 2'd0;
      d_wdata   <= 32'h0;
    end else if (bus.I_HREADY) begin
      d_valid <= a_move;
      if (a_move) begin
        d_write   <= a_write;
        d_addr_lo <= a_addr[1:0];
        d_size    <= a_size;
        d_wdata   <= place_lanes(a_size, a_wdata);
      end
    end
  end

  // Cancel covers the second ERROR cycle so the pending address is withdrawn.
  always_ff @(posedge I_HCLK or negedge I_HRESETn) begin
    if (!I_HRESETn) cancel <= 1'b0;
    else            cancel <= d_valid & bus.I_HRESP & ~bus.I_HREADY;
  end

  // One-cycle response pulse for a completed transfer or a local reject.
  always_ff @(posedge I_HCLK or negedge I_HRESETn) begin
    if (!I_HRESETn) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
    end else if (d_done) begin
      rsp_valid <= 1'b1;
      rsp_err   <= bus.I_HRESP;
      rsp_rdata <= (!d_write && !bus.I_HRESP) ? rd_extract : 32'h0;
    end else if (accept_mis) begin
      rsp_valid <= 1'b1;
      rsp_err   <= 1'b1;
      rsp_rdata <= 32'h0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
    end
  end

  assign bus.O_CMD_READY = cmd_ready;
  assign bus.O_RSP_VALID = rsp_valid;
  assign bus.O_RSP_RDATA = rsp_rdata;
  assign bus.O_RSP_ERR   = rsp_err;
  assign bus.O_HTRANS    = (a_valid && !cancel) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.O_HADDR     = a_addr;
  assign bus.O_HWRITE    = a_write;
  assign bus.O_HSIZE     = {1'b0, a_size};
  assign bus.O_HBURST    = 3'b000;
  assign bus.O_HMASTLOCK = 1'b0;
  assign bus.O_HPROT     = HPROT_VAL;
  assign bus.O_HWDATA    = d_wdata;

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Directed bench for ahb_lite_cmd_master: the bench plays the AHB slave by
// hand and checks bus and response outputs cycle by cycle.
module tb_ahb_lite_cmd_master;

  logic I_HCLK;
  logic I_HRESETn;
  int   tests_run;
  int   tests_failed;

  ahb_lite_cmd_master_if #(.ADDR_W(32)) bus ();

  ahb_lite_cmd_master #(.ADDR_W(32), .HPROT_VAL(4'b0011)) dut (
    .I_HCLK    (I_HCLK),
    .I_HRESETn (I_HRESETn),
    .bus       (bus)
  );

  initial I_HCLK = 1'b0;
  always #5 I_HCLK = ~I_HCLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic write, input logic [31:0] addr,
                               input logic [1:0] size, input logic [31:0] wdata);
    bus.I_CMD_VALID = valid;
    bus.I_CMD_WRITE = write;
    bus.I_CMD_ADDR  = addr;
    bus.I_CMD_SIZE  = size;
    bus.I_CMD_WDATA = wdata;
  endtask

  task automatic idleCmd();
    applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
  endtask

  task automatic driveSlave(input logic ready, input logic resp, input logic [31:0] rdata);
    bus.I_HREADY = ready;
    bus.I_HRESP  = resp;
    bus.I_HRDATA = rdata;
  endtask

  task automatic nextCycle();
    @(posedge I_HCLK);
    #1;
  endtask

  task automatic sampleOutputs();
    @(negedge I_HCLK);
  endtask

  task automatic checkRsp(input string tag, input logic valid, input logic err, input logic [31:0] rdata);
    checkOutput({tag, "_rsp_valid"}, 32'(bus.O_RSP_VALID), 32'(valid));
    checkOutput({tag, "_rsp_err"},   32'(bus.O_RSP_ERR),   32'(err));
    checkOutput({tag, "_rsp_rdata"}, bus.O_RSP_RDATA,      rdata);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    I_HRESETn    = 1'b0;
    idleCmd();
    driveSlave(1'b1, 1'b0, 32'h0);

    // Reset values
    repeat (2) @(posedge I_HCLK);
    sampleOutputs();
    checkOutput("rst_htrans",    32'(bus.O_HTRANS),    32'h0);
    checkOutput("rst_hburst",    32'(bus.O_HBURST),    32'h0);
    checkOutput("rst_hmastlock", 32'(bus.O_HMASTLOCK), 32'h0);
    checkOutput("rst_hprot",     32'(bus.O_HPROT),     32'h3);
    checkOutput("rst_haddr",     bus.O_HADDR,          32'h0);
    checkOutput("rst_hwdata",    bus.O_HWDATA,         32'h0);
    checkOutput("rst_cmd_ready", 32'(bus.O_CMD_READY), 32'h0);
    checkOutput("rst_rsp_valid", 32'(bus.O_RSP_VALID), 32'h0);
    nextCycle();
    I_HRESETn = 1'b1;
    nextCycle();
    sampleOutputs();
    checkOutput("idle_cmd_ready", 32'(bus.O_CMD_READY), 32'h1);
    checkOutput("idle_htrans",    32'(bus.O_HTRANS),    32'h0);
    checkOutput("idle_rsp_valid", 32'(bus.O_RSP_VALID), 32'h0);

    // Word write then word read, back to back
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h100, 2'd2, 32'hDEADBEEF);
    sampleOutputs();
    checkOutput("w_ready", 32'(bus.O_CMD_READY), 32'h1);
    checkOutput("w_htrans_pre", 32'(bus.O_HTRANS), 32'h0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h100, 2'd2, 32'h0);
    sampleOutputs();
    checkOutput("w_htrans", 32'(bus.O_HTRANS), 32'h2);
    checkOutput("w_haddr",  bus.O_HADDR,       32'h100);
    checkOutput("w_hwrite", 32'(bus.O_HWRITE), 32'h1);
    checkOutput("w_hsize",  32'(bus.O_HSIZE),  32'h2);
    nextCycle();
    idleCmd();
    sampleOutputs();
    checkOutput("r_htrans", 32'(bus.O_HTRANS), 32'h2);
    checkOutput("r_haddr",  bus.O_HADDR,       32'h100);
    checkOutput("r_hwrite", 32'(bus.O_HWRITE), 32'h0);
    checkOutput("w_hwdata", bus.O_HWDATA,      32'hDEADBEEF);
    checkOutput("wr_rsp_none", 32'(bus.O_RSP_VALID), 32'h0);
    nextCycle();
    driveSlave(1'b1, 1'b0, 32'hDEADBEEF);
    sampleOutputs();
    checkRsp("w", 1'b1, 1'b0, 32'h0);
    checkOutput("wr_htrans_idle", 32'(bus.O_HTRANS), 32'h0);
    nextCycle();
    sampleOutputs();
    checkRsp("r", 1'b1, 1'b0, 32'hDEADBEEF);
    nextCycle();
    sampleOutputs();
    checkOutput("wr_rsp_end", 32'(bus.O_RSP_VALID), 32'h0);

    // Byte write, byte read, halfword read with lane steering
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h103, 2'd0, 32'h000000A5);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h103, 2'd0, 32'h0);
    sampleOutputs();
    checkOutput("bw_hsize",  32'(bus.O_HSIZE),  32'h0);
    checkOutput("bw_haddr",  bus.O_HADDR,       32'h103);
    checkOutput("bw_hwrite", 32'(bus.O_HWRITE), 32'h1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h102, 2'd1, 32'h0);
    sampleOutputs();
    checkOutput("bw_hwdata", bus.O_HWDATA, 32'hA5A5A5A5);
    checkOutput("br_haddr",  bus.O_HADDR,  32'h103);
    nextCycle();
    idleCmd();
    driveSlave(1'b1, 1'b0, 32'h12345678);
    sampleOutputs();
    checkOutput("hr_haddr", bus.O_HADDR,      32'h102);
    checkOutput("hr_hsize", 32'(bus.O_HSIZE), 32'h1);
    checkRsp("bw", 1'b1, 1'b0, 32'h0);
    nextCycle();
    sampleOutputs();
    checkRsp("br", 1'b1, 1'b0, 32'h00000012);
    nextCycle();
    sampleOutputs();
    checkRsp("hr", 1'b1, 1'b0, 32'h00001234);
    checkOutput("hr_htrans_idle", 32'(bus.O_HTRANS), 32'h0);

    // Three wait states on a write with a read pending in address phase
    nextCycle();
    driveSlave(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h300, 2'd2, 32'h11223344);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h304, 2'd2, 32'h0);
    nextCycle();
    idleCmd();
    driveSlave(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      sampleOutputs();
      checkOutput("ws_htrans", 32'(bus.O_HTRANS),    32'h2);
      checkOutput("ws_haddr",  bus.O_HADDR,          32'h304);
      checkOutput("ws_hwdata", bus.O_HWDATA,         32'h11223344);
      checkOutput("ws_ready",  32'(bus.O_CMD_READY), 32'h0);
      checkOutput("ws_rsp",    32'(bus.O_RSP_VALID), 32'h0);
      nextCycle();
    end
    driveSlave(1'b1, 1'b0, 32'h0);
    sampleOutputs();
    checkOutput("ws_release_haddr", bus.O_HADDR, 32'h304);
    nextCycle();
    driveSlave(1'b1, 1'b0, 32'hCAFEF00D);
    sampleOutputs();
    checkRsp("ws_w", 1'b1, 1'b0, 32'h0);
    nextCycle();
    sampleOutputs();
    checkRsp("ws_r", 1'b1, 1'b0, 32'hCAFEF00D);

    // ERROR on read 0x200 with read 0x204 pipelined behind it
    nextCycle();
    driveSlave(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h200, 2'd2, 32'h0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h204, 2'd2, 32'h0);
    nextCycle();
    idleCmd();
    driveSlave(1'b0, 1'b1, 32'h0);
    sampleOutputs();
    checkOutput("e1_htrans", 32'(bus.O_HTRANS), 32'h2);
    checkOutput("e1_haddr",  bus.O_HADDR,       32'h204);
    nextCycle();
    driveSlave(1'b1, 1'b1, 32'h0);
    sampleOutputs();
    checkOutput("e2_htrans", 32'(bus.O_HTRANS),    32'h0);
    checkOutput("e2_ready",  32'(bus.O_CMD_READY), 32'h0);
    nextCycle();
    driveSlave(1'b1, 1'b0, 32'h0);
    sampleOutputs();
    checkRsp("e_err", 1'b1, 1'b1, 32'h0);
    checkOutput("e_reissue_htrans", 32'(bus.O_HTRANS), 32'h2);
    checkOutput("e_reissue_haddr",  bus.O_HADDR,       32'h204);
    nextCycle();
    driveSlave(1'b1, 1'b0, 32'h55AA55AA);
    sampleOutputs();
    checkOutput("e_gap_rsp", 32'(bus.O_RSP_VALID), 32'h0);
    checkOutput("e_gap_htrans", 32'(bus.O_HTRANS), 32'h0);
    nextCycle();
    sampleOutputs();
    checkRsp("e_ok", 1'b1, 1'b0, 32'h55AA55AA);

    // Misaligned WORD at 0x102 with the bus idle
    nextCycle();
    driveSlave(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h102, 2'd2, 32'h0);
    sampleOutputs();
    checkOutput("mis_ready", 32'(bus.O_CMD_READY), 32'h1);
    nextCycle();
    idleCmd();
    sampleOutputs();
    checkRsp("mis", 1'b1, 1'b1, 32'h0);
    checkOutput("mis_htrans", 32'(bus.O_HTRANS), 32'h0);
    nextCycle();
    sampleOutputs();
    checkOutput("mis_rsp_end", 32'(bus.O_RSP_VALID), 32'h0);

    // Misaligned command offered while a read is in flight
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h400, 2'd2, 32'h0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h102, 2'd2, 32'h0);
    sampleOutputs();
    checkOutput("misb_ready_a", 32'(bus.O_CMD_READY), 32'h0);
    checkOutput("misb_haddr",   bus.O_HADDR,          32'h400);
    nextCycle();
    driveSlave(1'b1, 1'b0, 32'h0BADF00D);
    sampleOutputs();
    checkOutput("misb_ready_d", 32'(bus.O_CMD_READY), 32'h0);
    checkOutput("misb_htrans",  32'(bus.O_HTRANS),    32'h0);
    nextCycle();
    sampleOutputs();
    checkOutput("misb_ready_free", 32'(bus.O_CMD_READY), 32'h1);
    checkRsp("misb_rd", 1'b1, 1'b0, 32'h0BADF00D);
    nextCycle();
    idleCmd();
    sampleOutputs();
    checkRsp("misb_rej", 1'b1, 1'b1, 32'h0);
    checkOutput("misb_htrans_end", 32'(bus.O_HTRANS), 32'h0);

    // Reset asserted mid-transfer returns the bus to IDLE at once
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h500, 2'd2, 32'h01020304);
    nextCycle();
    idleCmd();
    sampleOutputs();
    checkOutput("mr_htrans_busy", 32'(bus.O_HTRANS), 32'h2);
    #1;
    I_HRESETn = 1'b0;
    #1;
    checkOutput("mr_htrans", 32'(bus.O_HTRANS),    32'h0);
    checkOutput("mr_haddr",  bus.O_HADDR,          32'h0);
    checkOutput("mr_ready",  32'(bus.O_CMD_READY), 32'h0);
    nextCycle();
    nextCycle();
    I_HRESETn = 1'b1;
    nextCycle();
    nextCycle();
    sampleOutputs();
    checkOutput("mr_rsp_none", 32'(bus.O_RSP_VALID), 32'h0);
    checkOutput("mr_htrans_idle", 32'(bus.O_HTRANS), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ahb_lite_cmd_master.md
Name: ahb_lite_cmd_master

Overview:
AHB-lite single-master initiator that turns a simple command stream into AHB-lite single transfers (NONSEQ, SINGLE) of BYTE, HWORD or WORD size. It drives the bus that slave-side blocks such as the single-port SRAM bridge respond to. It supports pipelined back-to-back transfers, HREADY wait states, the two-cycle ERROR response and little-endian byte-lane steering. Each completed transfer returns one response record.

Parameters:
ADDR_W, 32, width of I_CMD_ADDR and O_HADDR (min 12)
HPROT_VAL, 4'b0011, constant driven on O_HPROT (non-cacheable, non-bufferable, privileged, data)

Ports:
I_HCLK  in  1  clock
I_HRESETn  in  1  reset, asynchronous, active-low
I_CMD_VALID  in  1  command present
O_CMD_READY  out  1  command accepted on clock edge when VALID&READY
I_CMD_WRITE  in  1  1=write, 0=read
I_CMD_ADDR  in  ADDR_W  byte address
I_CMD_SIZE  in  2  0=BYTE, 1=HWORD, 2=WORD, 3=illegal
I_CMD_WDATA  in  32  write data, right-justified (bits [8<<size-1:0] used)
O_RSP_VALID  out  1  one-cycle response pulse, no backpressure
O_RSP_RDATA  out  32  read data, right-justified, zero-extended; 0 for writes/errors
O_RSP_ERR  out  1  1=bus ERROR or local misalignment reject
O_HADDR  out  ADDR_W  AHB address
O_HTRANS  out  2  IDLE=00 / NONSEQ=10 only
O_HWRITE  out  1  AHB write
O_HSIZE  out  3  {1'b0,size}
O_HBURST  out  3  constant 000 (SINGLE)
O_HMASTLOCK  out  1  constant 0
O_HPROT  out  4  constant HPROT_VAL
O_HWDATA  out  32  write data on byte lanes, held during data phase
I_HRDATA  in  32  read data
I_HREADY  in  1  transfer-complete / bus ready
I_HRESP  in  1  0=OKAY, 1=ERROR

Behaviour:
- Reset: all O_H* outputs 0 (HTRANS=IDLE), HPROT=HPROT_VAL, O_CMD_READY=0 during reset, O_RSP_VALID/RDATA/ERR=0. All pipeline slots are emptied.
- Two registered slots. A-slot holds the address phase (valid, addr, size, write, wdata). D-slot holds the data phase (valid, write, addr[1:0], size, lane wdata).
- O_HTRANS=NONSEQ iff A-slot valid and not cancelled. O_HADDR/HWRITE/HSIZE come from the A-slot and hold while HREADY=0.
- Aligned command acceptance: O_CMD_READY = (~A_valid | I_HREADY) & ~cancel.
- Slot advance: at an edge with I_HREADY=1, the A-slot moves to the D-slot; the D-slot completes. Throughput is one transfer per cycle with zero wait states.
- O_HWDATA is registered from the D-slot and is stable for the whole data phase, including wait cycles.
- Write lane placement, little-endian:
  - BYTE: data[7:0] replicated to all 4 lanes.
  - HWORD: data[15:0] replicated to both halves.
  - WORD: passed through.
- Read extraction: BYTE takes I_HRDATA[8*a+7:8*a] with a=addr[1:0]; HWORD takes the half selected by addr[1]; WORD takes the full word. The result is zero-extended.
- Response: the cycle after a D-slot edge with HREADY=1, O_RSP_VALID=1 and O_RSP_ERR=I_HRESP sampled at that edge. Responses are issued in command order.
- ERROR handling:
  - First ERROR cycle (D_valid, HRESP=1, HREADY=0): at that edge, set cancel.
  - During cancel, O_HTRANS=IDLE and O_CMD_READY=0. The A-slot contents are retained and do not advance at the second-cycle HREADY=1 edge.
  - The cycle after, cancel clears and the A-slot re-issues as NONSEQ.
  - The errored transfer returns ERR=1. The cancelled transfer is not dropped and gets its own later response.
- Misaligned command: HWORD with addr[0]=1, WORD with addr[1:0]!=0, or size=3.
  - Accepted only when both slots are empty and cancel=0 (otherwise READY=0).
  - Never reaches the bus.
  - Next cycle: O_RSP_VALID=1, ERR=1, RDATA=0.
- Simultaneous events: a new accept and an A→D advance on the same edge is legal (pipelined overlap). A D completion and a misaligned reject never coincide, by the acceptance rule.
- Reset mid-transfer: the bus returns to IDLE immediately. No response is issued for in-flight commands.
- Address wraps naturally at 2^ADDR_W. No burst logic.

Test Plan:
- Reset then idle: HTRANS=00, HBURST=000, HMASTLOCK=0, HPROT=0011, CMD_READY=1 after reset release, RSP_VALID=0.
- Word write 0x100=0xDEADBEEF then read 0x100 back-to-back, HREADY=1 → NONSEQ on consecutive cycles. HWDATA=0xDEADBEEF in read's address cycle. Read response RDATA=0xDEADBEEF, ERR=0, two RSP_VALID pulses.
- Byte write 0x103=0xA5 → HSIZE=000, HADDR=0x103, HWDATA=0xA5A5A5A5. Then byte read 0x103 with HRDATA=0x12345678 → RDATA=0x00000012. HWORD read 0x102 → 0x00001234.
- Slave inserts 3 HREADY=0 cycles on a write with a second command pending → HADDR/HTRANS of second command and HWDATA of first held stable for 3 cycles. Both respond in order.
- ERROR on read 0x200 with read 0x204 pipelined → HTRANS=IDLE in second ERROR cycle. 0x204 re-issued NONSEQ next cycle. Responses: ERR=1 then ERR=0.
- WORD command at 0x102 with bus idle → no NONSEQ, RSP_VALID next cycle with ERR=1, RDATA=0. Same command offered during an active transfer → CMD_READY=0 until both slots empty.
